// File: rtl/vc_credit_recv_queue.sv
// Receiver-side buffer for a credit-flow-controlled link: accepts messages without
// backpressure, delivers them over val/rdy and returns one credit pulse per dequeue.
module vc_credit_recv_queue #(
  parameter  int p_msg_nbits   = 32,
  parameter  int p_num_entries = 4,
  localparam int c_cnt_nbits   = $clog2(p_num_entries + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enq_val,
  input  logic [p_msg_nbits-1:0] enq_msg,
  output logic                   deq_val,
  input  logic                   deq_rdy,
  output logic [p_msg_nbits-1:0] deq_msg,
  output logic                   credit,
  output logic [c_cnt_nbits-1:0] num_entries,
  output logic                   overflow
);

  localparam int                     c_ptr_nbits = $clog2(p_num_entries);
  localparam logic [c_ptr_nbits-1:0] c_last_ptr  = c_ptr_nbits'(p_num_entries - 1);
  localparam logic [c_cnt_nbits-1:0] c_full_cnt  = c_cnt_nbits'(p_num_entries);

  logic [p_msg_nbits-1:0] storage [p_num_entries];
  logic [c_ptr_nbits-1:0] head;
  logic [c_ptr_nbits-1:0] tail;
  logic [c_cnt_nbits-1:0] count;
  logic                   full;
  logic                   deq_go;
  logic                   enq_go;

  // Depth need not be a power of two, so wrap by compare rather than by truncation.
  function automatic logic [c_ptr_nbits-1:0] ptr_inc(input logic [c_ptr_nbits-1:0] ptr);
    return (ptr == c_last_ptr) ? '0 : ptr + 1'b1;
  endfunction

  assign full        = (count == c_full_cnt);
  assign deq_val     = (count != '0);
  assign deq_go      = deq_val && deq_rdy;
  // A dequeue in the same cycle frees the slot, so full-with-dequeue is accepted.
  assign enq_go      = enq_val && (!full || deq_go);
  assign deq_msg     = storage[head];
  assign num_entries = count;

  // NOTE: the storage array carries no reset; occupancy and pointers alone decide
  // what is valid, and leaving it unreset lets it map onto plain RAM/flop arrays.
  always_ff @(posedge clk) begin
    if (enq_go) storage[tail] <= enq_msg;
  end

  // NOTE: every register update uses <= so all state moves together on the edge
  // and the order of statements inside the block does not matter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      credit   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      credit <= deq_go;
      if (enq_go) tail <= ptr_inc(tail);
      if (deq_go) head <= ptr_inc(head);
      if (enq_go && !deq_go)      count <= count + 1'b1;
      else if (deq_go && !enq_go) count <= count - 1'b1;
      // Sender pushed into a full queue with nothing leaving: drop it, flag forever.
      if (enq_val && !enq_go) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vc_credit_recv_queue.sv
// Bench for vc_credit_recv_queue: a depth-4 lane runs directed scenarios and a depth-3
// lane runs a randomized credit-respecting stream; both are scored against a queue model.
module tb_vc_credit_recv_queue;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit done0    = 1'b0;
  bit done1    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g_lane
    localparam int N  = (k == 0) ? 4 : 3;
    localparam int CW = $clog2(N + 1);

    logic          reset;
    logic          enq_val;
    logic [W-1:0]  enq_msg;
    logic          deq_val;
    logic          deq_rdy;
    logic [W-1:0]  deq_msg;
    logic          credit;
    logic [CW-1:0] num_entries;
    logic          overflow;

    logic [W-1:0]  sb_q [$];
    bit            exp_credit   = 1'b0;
    bit            exp_ovf      = 1'b0;
    bit            m_deq_go     = 1'b0;
    int            credits_seen = 0;
    int            msgs_out     = 0;

    vc_credit_recv_queue #(.p_msg_nbits(W), .p_num_entries(N)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .enq_val     (enq_val),
      .enq_msg     (enq_msg),
      .deq_val     (deq_val),
      .deq_rdy     (deq_rdy),
      .deq_msg     (deq_msg),
      .credit      (credit),
      .num_entries (num_entries),
      .overflow    (overflow)
    );

    // Reference: a message queue of capacity N. The monitor pops at the negedge when a
    // dequeue happens, so at the edge an arrival fits iff fewer than N remain.
    always @(posedge clk or negedge reset) begin
      if (!reset) begin
        sb_q.delete();
        exp_credit = 1'b0;
        exp_ovf    = 1'b0;
        m_deq_go   = 1'b0;
      end else begin
        exp_credit = m_deq_go;
        m_deq_go   = 1'b0;
        if (enq_val) begin
          if (sb_q.size() < N) sb_q.push_back(enq_msg);
          else                 exp_ovf = 1'b1;
        end
      end
    end

    always @(negedge clk) begin
      check($sformatf("L%0d deq_val", k), 64'(deq_val), 64'(sb_q.size() != 0));
      check($sformatf("L%0d num_entries", k), 64'(num_entries), 64'(sb_q.size()));
      check($sformatf("L%0d credit", k), 64'(credit), 64'(exp_credit));
      check($sformatf("L%0d overflow", k), 64'(overflow), 64'(exp_ovf));
      if (credit === 1'b1) credits_seen++;
      if (reset && sb_q.size() != 0) begin
        check($sformatf("L%0d deq_msg", k), 64'(deq_msg), 64'(sb_q[0]));
        if (deq_rdy) begin
          void'(sb_q.pop_front());
          m_deq_go = 1'b1;
          msgs_out++;
        end
      end
    end

    task automatic step(input bit ev, input logic [W-1:0] msg, input bit rdy);
      enq_val = ev;
      enq_msg = msg;
      deq_rdy = rdy;
      @(posedge clk);
      #1;
    endtask

    if (k == 0) begin : g_dir
      initial begin : dir
        int c0;
        reset = 1'b0; enq_val = 1'b0; enq_msg = '0; deq_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("L0 rst deq_val", 64'(deq_val), 0);
        check("L0 rst credit", 64'(credit), 0);
        check("L0 rst overflow", 64'(overflow), 0);
        check("L0 rst num", 64'(num_entries), 0);
        reset = 1'b1;

        // Single message
        c0 = credits_seen;
        step(1'b1, 32'hA5, 1'b1);
        check("L0 a5 deq_val", 64'(deq_val), 1);
        check("L0 a5 deq_msg", 64'(deq_msg), 64'hA5);
        step(1'b0, '0, 1'b1);
        check("L0 a5 credit", 64'(credit), 1);
        step(1'b0, '0, 1'b0);
        check("L0 a5 credit low", 64'(credit), 0);
        step(1'b0, '0, 1'b0);
        check("L0 a5 credit count", 64'(credits_seen - c0), 1);

        // Fill to full, then drain
        for (int i = 1; i <= 4; i++) begin
          step(1'b1, W'(i), 1'b0);
          check("L0 fill num", 64'(num_entries), 64'(i));
          check("L0 fill head", 64'(deq_msg), 1);
        end
        c0 = credits_seen;
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        check("L0 drain num", 64'(num_entries), 0);
        check("L0 drain credits", 64'(credits_seen - c0), 4);

        // Enqueue and dequeue together while full
        for (int i = 1; i <= 4; i++) step(1'b1, 32'h100 + W'(i), 1'b0);
        c0 = credits_seen;
        for (int i = 0; i < 6; i++) begin
          step(1'b1, 32'h200 + W'(i), 1'b1);
          check("L0 steady credit", 64'(credit), 1);
          check("L0 steady num", 64'(num_entries), 4);
        end
        step(1'b0, '0, 1'b0);
        check("L0 steady overflow", 64'(overflow), 0);
        check("L0 steady credits", 64'(credits_seen - c0), 6);

        // Overflow: full, no dequeue
        c0 = credits_seen;
        step(1'b1, 32'hFF, 1'b0);
        check("L0 ovf set", 64'(overflow), 1);
        check("L0 ovf num", 64'(num_entries), 4);
        step(1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        check("L0 ovf sticky", 64'(overflow), 1);
        check("L0 ovf drained", 64'(num_entries), 0);
        check("L0 ovf credits", 64'(credits_seen - c0), 4);

        // Asynchronous reset with two entries held and credit high
        for (int i = 0; i < 3; i++) step(1'b1, 32'h31 + W'(i), 1'b0);
        step(1'b0, '0, 1'b1);
        check("L0 pre-rst credit", 64'(credit), 1);
        check("L0 pre-rst num", 64'(num_entries), 2);
        #2;
        reset = 1'b0; enq_val = 1'b0; deq_rdy = 1'b0;
        #1;
        check("L0 async deq_val", 64'(deq_val), 0);
        check("L0 async credit", 64'(credit), 0);
        check("L0 async num", 64'(num_entries), 0);
        check("L0 async overflow", 64'(overflow), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        c0 = credits_seen;
        step(1'b1, 32'h77, 1'b1);
        check("L0 post-rst msg", 64'(deq_msg), 64'h77);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        check("L0 post-rst credits", 64'(credits_seen - c0), 1);
        check("L0 post-rst num", 64'(num_entries), 0);
        done0 = 1'b1;
      end
    end else begin : g_rnd
      initial begin : rnd
        int cred;
        int sent;
        int guard;
        bit ev;
        reset = 1'b0; enq_val = 1'b0; enq_msg = '0; deq_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        cred  = N;
        sent  = 0;
        guard = 0;
        // Sender model: only sends while holding a credit; each returned pulse refunds one.
        while (msgs_out < 10 && guard < 2000) begin
          if (credit === 1'b1 && cred < N) cred++;
          ev = (sent < 10) && (cred > 0) && ($urandom_range(0, 3) != 0);
          if (ev) begin
            cred--;
            sent++;
          end
          step(ev, W'($urandom), 1'($urandom_range(0, 1)));
          guard++;
        end
        check("L1 stream delivered", 64'(msgs_out), 10);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        check("L1 total credits", 64'(credits_seen), 10);
        check("L1 overflow", 64'(overflow), 0);
        check("L1 empty", 64'(num_entries), 0);
        done1 = 1'b1;
      end
    end
  end

  initial begin : top
    int cyc;
    cyc = 0;
    while (!(done0 && done1) && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    check("run completion", 64'(done0 && done1), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vc_credit_recv_queue.md
# vc_credit_recv_queue

Receiver end of the credit-based flow-control link whose transmit side holds a saturating up/down credit counter. It accepts messages with no backpressure, since the sender only sends when it holds a credit. Messages are buffered in a circular FIFO and delivered downstream over a val/rdy interface. One credit pulse goes back to the sender per message dequeued. The block sits at the input of each network/memory port that is fed by a credit-counting sender.

## Interface
Parameters:
- p_msg_nbits, 32, message width in bits.
- p_num_entries, 4, buffer depth (≥2, need not be a power of two). The sender's credit counter resets to and saturates at this value.
- c_cnt_nbits, derived as $clog2(p_num_entries+1), width of the occupancy count.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-low; the block is in reset while the signal is 0.
- enq_val, input, 1, incoming message valid; there is no enq_rdy.
- enq_msg, input, p_msg_nbits, incoming message.
- deq_val, output, 1, the head entry is valid.
- deq_rdy, input, 1, the consumer accepts the head this cycle.
- deq_msg, output, p_msg_nbits, the head entry; don't-care while deq_val=0.
- credit, output, 1, registered one-cycle pulse that returns one credit to the sender.
- num_entries, output, c_cnt_nbits, current occupancy.
- overflow, output, 1, sticky error flag.

## Operation
- State: storage array, head and tail pointers, occupancy count, credit register, overflow register. The storage array is not reset.
- Pointers wrap from p_num_entries-1 to 0 by explicit compare, not by power-of-two truncation.
- Define enq_go = enq_val && (count < p_num_entries || deq_go).
- Define deq_go = deq_val && deq_rdy.
- On enq_go: write enq_msg at tail and advance tail.
- On deq_go: advance head.
- Count update: +1 on enq_go only, -1 on deq_go only, unchanged when both occur.
- Enqueue when full with a dequeue in the same cycle is accepted. This is normal steady state at full credit utilisation.
- Enqueue when full with no dequeue is a protocol violation by the sender:
  - the message is dropped, and state other than overflow is unchanged;
  - overflow sets to 1 and stays set until reset.
- deq_val = (count != 0).
- deq_msg = storage[head]. No enq-to-deq bypass: a message written while the queue is empty is not visible in the same cycle.
- credit register loads deq_go every cycle, so each dequeue produces exactly one pulse. Back-to-back dequeues produce a continuous high credit.
- Dropped (overflow) messages return no credit.
- Reset asserted mid-operation:
  - all buffered entries are discarded immediately (asynchronously);
  - no credits are returned for them;
  - the sender's counter must be reset by the same reset, back to p_num_entries.

## Timing
- Reset values: deq_val=0, num_entries=0, credit=0, overflow=0, head=tail=0.
- Enqueue-to-dequeue latency is 1 cycle: enq_val at edge N gives deq_val=1 after edge N.
- Dequeue-to-credit latency is 1 cycle: deq_go in cycle N gives credit=1 in cycle N+1.
- Full-loop turnaround is 2 cycles from the dequeue cycle to the sender being able to reuse the credit (credit pulse, then counter increment).
- All outputs come from registers or from a registered mux (deq_msg). There is no combinational path from enq_* to any output.
- deq_rdy does affect enqueue acceptance when full.
- deq_rdy may toggle freely. deq_val and deq_msg hold stable while deq_val=1 and deq_rdy=0.

## Test plan
- Reset and basic single message:
  - Stimulus: hold reset=0 for 2 cycles, then release. Enqueue 0xA5 with deq_rdy=1.
  - Response: all outputs are 0 during reset. deq_val=1 with deq_msg=0xA5 one cycle after the enqueue. credit pulses exactly once, one cycle after the dequeue.
- Fill to full with p_num_entries=4:
  - Stimulus: deq_rdy=0; enqueue 1, 2, 3, 4.
  - Response: num_entries goes 1→2→3→4, and deq_msg holds 1 throughout.
  - Then: raise deq_rdy.
  - Response: dequeue order is 1, 2, 3, 4; four credit pulses; num_entries returns to 0.
- Simultaneous enqueue and dequeue at full:
  - Stimulus: with the queue full, assert enq_val=1 and deq_rdy=1 for 6 cycles.
  - Response: num_entries stays 4, overflow stays 0, credit is high for 6 consecutive cycles, and output order is preserved.
- Pointer wrap with non-power-of-two depth:
  - Stimulus: p_num_entries=3; stream 10 messages under random deq_rdy, never overflowing.
  - Response: data comes out in order; total credits = 10.
- Overflow:
  - Stimulus: with the queue full and deq_rdy=0, enqueue 0xFF.
  - Response: overflow=1 from the next cycle and stays set; num_entries stays 4; 0xFF never appears on deq_msg; no credit is issued.
- Reset mid-stream:
  - Stimulus: with 2 entries buffered and credit high, drive reset=0 asynchronously between edges.
  - Response: deq_val, credit and num_entries fall to 0 immediately. After release the queue is empty and operates normally.
